// File: rtl/pipeline_pkg.sv
// Shared stage indices and scoreboard entry layout for the forwarding/hazard
// scoreboard tracking in-flight writers between EX and WB.
package pipeline_pkg;

  localparam int PL_EX  = 0;
  localparam int PL_MEM = 1;
  localparam int PL_WB  = 2;

  // Wide enough for any stage index up to the 8-stage maximum.
  localparam int READY_W = 3;

  typedef struct packed {
    logic               valid;
    logic [4:0]         rd;
    logic [READY_W-1:0] ready;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_lookup.sv
// Per-source priority match over the scoreboard: picks the youngest writer of
// the source register and decides between forwarding and raising a hazard.
module scoreboard_lookup
  import pipeline_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int XLEN   = 32
) (
  input  sb_entry_t [STAGES-1:0]            entries,
  input  logic      [STAGES-1:0][XLEN-1:0]  stage_value,
  input  logic      [4:0]                   addr,
  input  logic                              use_src,
  output logic                              fwd,
  output logic      [XLEN-1:0]              fwd_val,
  output logic                              hazard
);

  logic               found;
  logic [READY_W-1:0] match_idx;
  logic [READY_W-1:0] match_ready;
  logic [XLEN-1:0]    match_val;

  // NOTE: every variable gets a default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    found       = 1'b0;
    match_idx   = '0;
    match_ready = '0;
    match_val   = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (!found && addr != 5'd0 && entries[k].valid && entries[k].rd == addr) begin
        found       = 1'b1;
        match_idx   = READY_W'(k);
        match_ready = entries[k].ready;
        match_val   = stage_value[k];
      end
    end
  end

  // The youngest match decides alone, even when it is not ready yet.
  assign fwd     = found && (match_idx >= match_ready);
  assign hazard  = found && (match_idx <  match_ready) && use_src;
  assign fwd_val = fwd ? match_val : '0;

endmodule

// File: rtl/pipeline_scoreboard.sv
// Scoreboard shift register of in-flight destination registers feeding two
// source lookups, plus stall generation and a saturating stall counter.
module pipeline_scoreboard
  import pipeline_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            issue_valid,
  input  logic                            issue_writes,
  input  logic [4:0]                      issue_rd,
  input  logic [$clog2(STAGES)-1:0]       issue_ready,
  input  logic                            flush,
  input  logic [4:0]                      rs1_addr,
  input  logic [4:0]                      rs2_addr,
  input  logic                            rs1_use,
  input  logic                            rs2_use,
  input  logic [STAGES-1:0][XLEN-1:0]     stage_value,
  output logic                            fwd1,
  output logic                            fwd2,
  output logic [XLEN-1:0]                 fwd1_val,
  output logic [XLEN-1:0]                 fwd2_val,
  output logic                            stall,
  output logic [CNT_W-1:0]                stall_cycles,
  input  logic                            clear_count
);

  sb_entry_t [STAGES-1:0] entries;
  sb_entry_t              new_entry;
  logic                   hazard1;
  logic                   hazard2;

  always_comb begin
    new_entry.valid = issue_valid && issue_writes && (issue_rd != 5'd0) && !stall && !flush;
    new_entry.rd    = issue_rd;
    new_entry.ready = READY_W'(issue_ready);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the async reset clears entries the moment it asserts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries <= '0;
    end else begin
      entries[STAGES-1:1] <= entries[STAGES-2:0];
      entries[0]          <= new_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (clear_count) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  scoreboard_lookup #(.STAGES(STAGES), .XLEN(XLEN)) u_lookup_rs1 (
    .entries     (entries),
    .stage_value (stage_value),
    .addr        (rs1_addr),
    .use_src     (rs1_use),
    .fwd         (fwd1),
    .fwd_val     (fwd1_val),
    .hazard      (hazard1)
  );

  scoreboard_lookup #(.STAGES(STAGES), .XLEN(XLEN)) u_lookup_rs2 (
    .entries     (entries),
    .stage_value (stage_value),
    .addr        (rs2_addr),
    .use_src     (rs2_use),
    .fwd         (fwd2),
    .fwd_val     (fwd2_val),
    .hazard      (hazard2)
  );

  assign stall = hazard1 || hazard2;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a history-queue model of in-flight writers.
module tb_pipeline_scoreboard;

  localparam int STAGES = 3;
  localparam int XLEN   = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        issue_valid, issue_writes, flush;
  logic [4:0]                  issue_rd, rs1_addr, rs2_addr;
  logic [$clog2(STAGES)-1:0]   issue_ready;
  logic                        rs1_use, rs2_use, clear_count;
  logic [STAGES-1:0][XLEN-1:0] stage_value;
  logic                        fwd1, fwd2, stall;
  logic [XLEN-1:0]             fwd1_val, fwd2_val;
  logic [CNT_W-1:0]            stall_cycles;

  int total = 0;
  int bad   = 0;

  pipeline_scoreboard #(.STAGES(STAGES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_writes (issue_writes),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .flush        (flush),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_use      (rs1_use),
    .rs2_use      (rs2_use),
    .stage_value  (stage_value),
    .fwd1         (fwd1),
    .fwd2         (fwd2),
    .fwd1_val     (fwd1_val),
    .fwd2_val     (fwd2_val),
    .stall        (stall),
    .stall_cycles (stall_cycles),
    .clear_count  (clear_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_writes = 1'b0;
    issue_rd     = 5'd0;
    issue_ready  = '0;
    flush        = 1'b0;
    rs1_addr     = 5'd0;
    rs2_addr     = 5'd0;
    rs1_use      = 1'b0;
    rs2_use      = 1'b0;
    clear_count  = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input int rdy);
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_rd     = rd;
    issue_ready  = rdy[1:0];
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  // Model: hist[k] is what was accepted k+1 cycles ago; older ones fall off.
  typedef struct { bit v; int rd; int rdy; } rec_t;
  rec_t hist[$];
  int   m_cnt;

  function automatic void model_lookup(input int addr, input bit use_src,
                                       output bit f, output logic [XLEN-1:0] v,
                                       output bit h);
    f = 0; v = '0; h = 0;
    for (int k = 0; k < hist.size(); k++) begin
      if (addr != 0 && hist[k].v && hist[k].rd == addr) begin
        if (k >= hist[k].rdy) begin
          f = 1;
          v = stage_value[k];
        end else begin
          h = use_src;
        end
        return;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    stage_value = '1;
    #1;
    total++;
    if (stall !== 1'b0 || fwd1 !== 1'b0 || fwd2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: stall=%b fwd1=%b fwd2=%b want 0 0 0", stall, fwd1, fwd2);
    end
    total++;
    if (fwd1_val !== '0 || fwd2_val !== '0 || stall_cycles !== '0) begin
      bad++;
      $display("FAIL reset_values: v1=%h v2=%h cnt=%0d want 0 0 0", fwd1_val, fwd2_val, stall_cycles);
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd5, 0);
    tick();
    idle();
    stage_value = '0;
    stage_value[0] = 32'h1234;
    rs1_addr = 5'd5;
    rs1_use  = 1'b1;
    #2;
    total++;
    if (fwd1 !== 1'b1 || fwd1_val !== 32'h1234 || stall !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back: fwd1=%b val=%h stall=%b want 1 1234 0", fwd1, fwd1_val, stall);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd6, 1);
    tick();
    idle();
    stage_value = '0;
    stage_value[1] = 32'hCAFE;
    rs2_addr = 5'd6;
    rs2_use  = 1'b1;
    issue(5'd10, 0);  // must be blocked by the stall
    #2;
    total++;
    if (stall !== 1'b1 || fwd2 !== 1'b0) begin
      bad++;
      $display("FAIL load_use_stall: stall=%b fwd2=%b want 1 0", stall, fwd2);
    end
    tick();
    issue_valid = 1'b0;
    rs1_addr = 5'd10;
    rs1_use  = 1'b1;
    #2;
    total++;
    if (stall !== 1'b0 || fwd2 !== 1'b1 || fwd2_val !== 32'hCAFE) begin
      bad++;
      $display("FAIL load_use_fwd: stall=%b fwd2=%b val=%h want 0 1 cafe", stall, fwd2, fwd2_val);
    end
    total++;
    if (stall_cycles !== 4'd1) begin
      bad++;
      $display("FAIL load_use_count: cnt=%0d want 1", stall_cycles);
    end
    total++;
    if (fwd1 !== 1'b0) begin
      bad++;
      $display("FAIL stalled_issue_dropped: fwd1=%b want 0", fwd1);
    end
  endtask

  task automatic test_priority();
    do_reset();
    issue(5'd7, 0);
    tick();
    issue(5'd8, 0);
    tick();
    issue(5'd7, 0);
    tick();
    idle();
    stage_value[0] = 32'hAAAA;
    stage_value[1] = 32'h5555;
    stage_value[2] = 32'hBBBB;
    rs1_addr = 5'd7; rs1_use = 1'b1;
    rs2_addr = 5'd7; rs2_use = 1'b1;
    #2;
    total++;
    if (fwd1 !== 1'b1 || fwd1_val !== 32'hAAAA || fwd2 !== 1'b1 || fwd2_val !== 32'hAAAA) begin
      bad++;
      $display("FAIL priority_youngest: f1=%b v1=%h f2=%b v2=%h want 1 aaaa 1 aaaa",
               fwd1, fwd1_val, fwd2, fwd2_val);
    end
    // Youngest not ready must stall even though an older ready copy exists.
    do_reset();
    issue(5'd7, 0);
    tick();
    issue(5'd7, 2);
    tick();
    idle();
    rs1_addr = 5'd7; rs1_use = 1'b1;
    #2;
    total++;
    if (fwd1 !== 1'b0 || stall !== 1'b1) begin
      bad++;
      $display("FAIL priority_not_ready: fwd1=%b stall=%b want 0 1", fwd1, stall);
    end
  endtask

  task automatic test_x0_flush();
    do_reset();
    issue(5'd0, 0);
    tick();
    issue(5'd9, 0);
    flush = 1'b1;
    tick();
    idle();
    rs1_addr = 5'd0; rs1_use = 1'b1;
    rs2_addr = 5'd9; rs2_use = 1'b1;
    #2;
    total++;
    if (fwd1 !== 1'b0 || fwd2 !== 1'b0 || stall !== 1'b0 || fwd1_val !== '0 || fwd2_val !== '0) begin
      bad++;
      $display("FAIL x0_flush: f1=%b f2=%b stall=%b v1=%h v2=%h want 0 0 0 0 0",
               fwd1, fwd2, stall, fwd1_val, fwd2_val);
    end
  endtask

  task automatic test_counter();
    int obs = 0;
    int n   = 0;
    do_reset();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    rs1_addr = 5'd11; rs1_use = 1'b1;
    issue(5'd11, 2);
    while (obs < 19 && n < 100) begin
      #2;
      if (stall === 1'b1) obs++;
      tick();
      n++;
      total++;
      if (int'(stall_cycles) != (obs > CNT_MAX ? CNT_MAX : obs)) begin
        bad++;
        $display("FAIL counter_step: cnt=%0d want %0d", stall_cycles,
                 (obs > CNT_MAX ? CNT_MAX : obs));
      end
    end
    total++;
    if (obs < 19) begin
      bad++;
      $display("FAIL counter_budget: stalls=%0d want 19", obs);
    end
    n = 0;
    #2;
    while (stall !== 1'b1 && n < 10) begin
      tick();
      #2;
      n++;
    end
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    total++;
    if (stall_cycles !== '0) begin
      bad++;
      $display("FAIL counter_clear: cnt=%0d want 0", stall_cycles);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(5'd6, 1);
    tick();
    idle();
    rs2_addr = 5'd6; rs2_use = 1'b1;
    #2;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: stall=%b want 1", stall);
    end
    reset = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || fwd1 !== 1'b0 || fwd2 !== 1'b0 || stall_cycles !== '0) begin
      bad++;
      $display("FAIL reset_mid: stall=%b f1=%b f2=%b cnt=%0d want 0 0 0 0",
               stall, fwd1, fwd2, stall_cycles);
    end
    tick();
    reset = 1'b0;
    tick();
    #2;
    total++;
    if (stall !== 1'b0 || fwd2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_after: stall=%b fwd2=%b want 0 0", stall, fwd2);
    end
  endtask

  task automatic test_random();
    bit f1, f2, h1, h2, s;
    logic [XLEN-1:0] v1, v2;
    rec_t r;
    do_reset();
    hist.delete();
    for (int k = 0; k < STAGES; k++) begin
      r.v = 0; r.rd = 0; r.rdy = 0;
      hist.push_back(r);
    end
    m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_writes = ($urandom_range(0, 4) != 0);
      issue_rd     = 5'($urandom_range(0, 7));
      issue_ready  = 2'($urandom_range(0, 2));
      flush        = ($urandom_range(0, 7) == 0);
      rs1_addr     = 5'($urandom_range(0, 7));
      rs2_addr     = 5'($urandom_range(0, 7));
      rs1_use      = $urandom_range(0, 1);
      rs2_use      = $urandom_range(0, 1);
      clear_count  = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < STAGES; k++) stage_value[k] = $urandom;
      #2;
      model_lookup(rs1_addr, rs1_use, f1, v1, h1);
      model_lookup(rs2_addr, rs2_use, f2, v2, h2);
      s = h1 || h2;
      total++;
      if (fwd1 !== f1 || fwd1_val !== v1 || fwd2 !== f2 || fwd2_val !== v2 ||
          stall !== s || int'(stall_cycles) != m_cnt) begin
        bad++;
        $display("FAIL random[%0d]: f1=%b v1=%h f2=%b v2=%h st=%b cnt=%0d want %b %h %b %h %b %0d",
                 c, fwd1, fwd1_val, fwd2, fwd2_val, stall, stall_cycles,
                 f1, v1, f2, v2, s, m_cnt);
      end
      r.v   = issue_valid && issue_writes && issue_rd != 0 && !s && !flush;
      r.rd  = issue_rd;
      r.rdy = issue_ready;
      hist.push_front(r);
      void'(hist.pop_back());
      if (clear_count) m_cnt = 0;
      else if (s && m_cnt < CNT_MAX) m_cnt++;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_x0_flush();
    test_counter();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
